pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline; sits beside the forwarding mux selects.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_MC_BUSY = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic s_if;
        logic s_id;
        logic s_ex;
        logic s_mem;
    } stall_vec_t;

    localparam int unsigned REG_X0 = 0;

    localparam stall_vec_t STALL_NONE  = 4'b0000;
    localparam stall_vec_t STALL_ALL   = 4'b1111;
    localparam stall_vec_t STALL_FRONT = 4'b1100;
    localparam stall_vec_t STALL_MC    = 4'b1110;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle between pipeline and sequencer
interface pipeline_hazard_ctrl_if #(
    parameter int AW        = 5,
    parameter int CNT_WIDTH = 32
);
    logic [AW-1:0]        id_rs1_addr;
    logic [AW-1:0]        id_rs2_addr;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [AW-1:0]        ex_rd_addr;
    logic                 ex_mem_read;
    logic                 ex_mc_op;
    logic                 ex_redirect;
    logic                 mc_done;
    logic                 dmem_req;
    logic                 dmem_ready;
    logic                 stall_if;
    logic                 stall_id;
    logic                 stall_ex;
    logic                 stall_mem;
    logic                 flush_id;
    logic                 flush_ex;
    logic                 bubble_mem;
    logic                 mc_start;
    logic                 mc_timeout;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_mem_read, ex_mc_op, ex_redirect,
               mc_done, dmem_req, dmem_ready,
        input  stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, bubble_mem, mc_start,
               mc_timeout, stall_count
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_mem_read, ex_mc_op, ex_redirect,
               mc_done, dmem_req, dmem_ready,
        output stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, bubble_mem, mc_start,
               mc_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - combinational load-use hazard compare
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] id_rs1_addr_i,
    input  logic [AW-1:0] id_rs2_addr_i,
    input  logic          id_rs1_used_i,
    input  logic          id_rs2_used_i,
    input  logic [AW-1:0] ex_rd_addr_i,
    input  logic          ex_mem_read_i,
    output logic          load_use_o
);
    logic rd_valid;
    logic rs1_hit;
    logic rs2_hit;

    // A load to x0 writes nothing, so it can never create a dependency.
    assign rd_valid   = ex_mem_read_i && (ex_rd_addr_i != AW'(REG_X0));
    assign rs1_hit    = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    assign load_use_o = rd_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_TIMEOUT     = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

    hz_state_t            state_q, state_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    stall_vec_t stv;
    logic       flush_id;
    logic       flush_ex;
    logic       bubble_mem;
    logic       mc_start;
    logic       mem_wait;
    logic       load_use;
    logic       tmo_hit;

    load_use_detect #(.AW(REG_ADDR_WIDTH)) u_load_use (
        .id_rs1_addr_i (hz.id_rs1_addr),
        .id_rs2_addr_i (hz.id_rs2_addr),
        .id_rs1_used_i (hz.id_rs1_used),
        .id_rs2_used_i (hz.id_rs2_used),
        .ex_rd_addr_i  (hz.ex_rd_addr),
        .ex_mem_read_i (hz.ex_mem_read),
        .load_use_o    (load_use)
    );

    assign mem_wait = hz.dmem_req && !hz.dmem_ready;
    assign tmo_hit  = !hz.mc_done && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = timeout_q;
        stv        = STALL_NONE;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        bubble_mem = 1'b0;
        mc_start   = 1'b0;
        // Outputs are gated by reset so an EX mc_op held through reset cannot fire mc_start.
        if (!rst_n) begin
            state_d = HZ_RUN;
        end else if (mem_wait) begin
            stv = STALL_ALL;
        end else begin
            unique case (state_q)
                HZ_RUN: begin
                    if (hz.ex_mc_op) begin
                        mc_start   = 1'b1;
                        stv        = STALL_MC;
                        bubble_mem = 1'b1;
                        tmo_cnt_d  = '0;
                        state_d    = HZ_MC_BUSY;
                    end else if (hz.ex_redirect) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (load_use) begin
                        stv      = STALL_FRONT;
                        flush_ex = 1'b1;
                    end
                end
                HZ_MC_BUSY: begin
                    if (hz.mc_done || tmo_hit) begin
                        tmo_cnt_d = '0;
                        state_d   = HZ_RUN;
                        if (tmo_hit) begin
                            timeout_d = 1'b1;
                        end
                    end else begin
                        stv        = STALL_MC;
                        bubble_mem = 1'b1;
                        tmo_cnt_d  = tmo_cnt_q + 1'b1;
                    end
                end
                default: state_d = HZ_RUN;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (stv.s_if && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HZ_RUN;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    assign hz.stall_if    = stv.s_if;
    assign hz.stall_id    = stv.s_id;
    assign hz.stall_ex    = stv.s_ex;
    assign hz.stall_mem   = stv.s_mem;
    assign hz.flush_id    = flush_id;
    assign hz.flush_ex    = flush_ex;
    assign hz.bubble_mem  = bubble_mem;
    assign hz.mc_start    = mc_start;
    assign hz.mc_timeout  = timeout_q;
    assign hz.stall_count = count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int TMO = 8;

    // Output vector order: stall_if stall_id stall_ex stall_mem flush_id flush_ex bubble_mem mc_start
    localparam logic [7:0] V_NONE  = 8'b0000_0000;
    localparam logic [7:0] V_LU    = 8'b1100_0100;
    localparam logic [7:0] V_START = 8'b1110_0011;
    localparam logic [7:0] V_BUSY  = 8'b1110_0010;
    localparam logic [7:0] V_WAIT  = 8'b1111_0000;
    localparam logic [7:0] V_REDIR = 8'b0000_1100;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   exp_cnt;

    pipeline_hazard_ctrl_if #(.AW(AW), .CNT_WIDTH(CW)) hz ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH (AW),
        .MC_TIMEOUT     (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    logic [7:0] outv;
    assign outv = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                   hz.flush_id, hz.flush_ex, hz.bubble_mem, hz.mc_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && hz.ex_mc_op && hz.ex_redirect)
            $error("decode exclusion broken: ex_mc_op and ex_redirect both high");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] exp_vec);
        @(negedge clk);
        chk(tag, {24'd0, outv}, {24'd0, exp_vec});
        if (exp_vec[7] && exp_cnt != (1 << CW) - 1) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.id_rs1_addr = '0; hz.id_rs2_addr = '0;
        hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
        hz.ex_rd_addr = '0; hz.ex_mem_read = 1'b0;
        hz.ex_mc_op = 1'b0; hz.ex_redirect = 1'b0;
        hz.mc_done = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_cnt = 0;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("rst_outs", {24'd0, outv}, 32'd0);
        chk("rst_cnt", {28'd0, hz.stall_count}, 32'd0);
        chk("rst_tmo", {31'd0, hz.mc_timeout}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // mul: start cycle + 5 busy cycles stalled, done on the 6th busy cycle
        hz.ex_mc_op = 1'b1;
        step("mc_start", V_START);
        for (int i = 0; i < 5; i++) step("mc_busy", V_BUSY);
        hz.mc_done = 1'b1;
        step("mc_done", V_NONE);
        hz.ex_mc_op = 1'b0;
        chk("mc_cnt6", {28'd0, hz.stall_count}, 32'd6);
        step("mc_done_run", V_NONE);
        hz.mc_done = 1'b0;

        // load-use on rs1, then bubble in EX
        hz.ex_mem_read = 1'b1; hz.ex_rd_addr = 5'd5;
        hz.id_rs1_addr = 5'd5; hz.id_rs1_used = 1'b1;
        step("lu_rs1", V_LU);
        hz.ex_mem_read = 1'b0;
        step("lu_after", V_NONE);

        // load to x0 never hazards
        hz.ex_mem_read = 1'b1; hz.ex_rd_addr = 5'd0; hz.id_rs1_addr = 5'd0;
        step("lu_x0", V_NONE);

        // rs2 match only counts when rs2 is used
        hz.ex_rd_addr = 5'd5; hz.id_rs1_addr = 5'd3;
        hz.id_rs2_addr = 5'd5; hz.id_rs2_used = 1'b0;
        step("lu_rs2_unused", V_NONE);
        hz.id_rs2_used = 1'b1;
        step("lu_rs2", V_LU);
        idle_inputs();
        chk("lu_cnt", {28'd0, hz.stall_count}, 32'd8);

        // withheld mc_done: 8th busy cycle aborts, counter saturates at 15
        hz.ex_mc_op = 1'b1;
        step("tmo_start", V_START);
        for (int i = 0; i < TMO - 1; i++) step("tmo_busy", V_BUSY);
        chk("tmo_pre", {31'd0, hz.mc_timeout}, 32'd0);
        step("tmo_abort", V_NONE);
        hz.ex_mc_op = 1'b0;
        chk("tmo_flag", {31'd0, hz.mc_timeout}, 32'd1);
        chk("cnt_sat", {28'd0, hz.stall_count}, 32'd15);
        chk("cnt_model", {28'd0, hz.stall_count}, exp_cnt);

        // memory wait with pending redirect: 3 frozen cycles then flush
        hz.ex_redirect = 1'b1; hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mw_hold", V_WAIT);
        hz.dmem_ready = 1'b1;
        step("mw_redirect", V_REDIR);
        idle_inputs();
        chk("tmo_sticky", {31'd0, hz.mc_timeout}, 32'd1);
        chk("cnt_hold15", {28'd0, hz.stall_count}, 32'd15);

        // reset asserted on the second MC_BUSY cycle
        hz.ex_mc_op = 1'b1;
        step("rst_mc_start", V_START);
        step("rst_mc_busy1", V_BUSY);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {24'd0, outv}, 32'd0);
        chk("rst_mid_cnt", {28'd0, hz.stall_count}, 32'd0);
        chk("rst_mid_tmo", {31'd0, hz.mc_timeout}, 32'd0);
        exp_cnt = 0;
        @(posedge clk); #1;
        hz.ex_mc_op = 1'b0;
        rst_n = 1'b1;
        step("post_rst_run", V_NONE);
        hz.ex_redirect = 1'b1;
        step("post_rst_redir", V_REDIR);
        idle_inputs();
        chk("post_rst_cnt", {28'd0, hz.stall_count}, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
